fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the core, directly upstream of decode/ImmGen.
- Owns the PC, issues word reads to instruction memory over a req/gnt + rvalid interface, and buffers returned words in a small FIFO.
- Presents {instr, pc} to decode with a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, instruction FIFO entries; also the limit on (outstanding requests + FIFO occupancy). Power of two, ≥2.
- MEM_BIG_ENDIAN, 1, when 1 each returned word is byte-swapped (ENDIAN_SWP_32 semantics) before enqueue.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- o_imem_req, output, 1, read request valid.
- o_imem_addr, output, 32, word-aligned byte address (bits [1:0] = 0).
- i_imem_gnt, input, 1, request accepted this cycle (req && gnt = issue).
- i_imem_rvalid, input, 1, response valid; responses return in issue order, latency ≥1 cycle.
- i_imem_rdata, input, 32, response word.
- i_redirect, input, 1, redirect request (single-cycle pulse).
- i_redirect_pc, input, 32, redirect target; bits [1:0] ignored.
- o_valid, output, 1, head FIFO entry valid to decode.
- i_ready, input, 1, decode accepts head (o_valid && i_ready = pop).
- o_instr, output, 32, instruction word (little-endian after optional swap).
- o_pc, output, 32, address the instruction was fetched from.

Behaviour:
- Reset (synchronous, when i_rst is high at the clock edge):
  - pc = RESET_PC, FIFO empty, outstanding = 0, discard = 0, state = RUN.
  - Outputs: o_imem_req = 0, o_valid = 0, o_instr = 0, o_pc = 0.
  - A reset in the middle of any operation drops all buffered and in-flight state. Responses arriving after reset that belong to earlier requests are not tracked; the memory is reset together with this block.
- Counters:
  - outstanding: 0..DEPTH. +1 on issue, −1 on an rvalid that is not discarded.
  - A simultaneous issue and response leave outstanding unchanged.
- Issue:
  - o_imem_req = (state == RUN) && !i_redirect && (outstanding + fifo_count < DEPTH).
  - o_imem_addr = pc.
  - On issue, pc <= pc + 4. The PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - A request issued in cycle N reaches o_valid no earlier than cycle N+2 (memory latency 1 + enqueue register).
- Enqueue:
  - A non-discarded rvalid pushes {swap(rdata), pc_of_that_request}.
  - The PC of each in-flight request is held in a DEPTH-entry tag queue.
  - The FIFO can never overflow because of the credit rule. Overflow is an assertion failure.
- Dequeue:
  - o_valid = !fifo_empty. o_instr and o_pc come from the head entry; they are registered FIFO outputs with no combinational path from rdata.
  - A push and pop in the same cycle are allowed, including when the FIFO is full.
- FSM with two states, RUN and DRAIN:
  - RUN + i_redirect:
    - FIFO flushed. o_valid = 0 the next cycle, even if a pop happened in the same cycle.
    - pc <= {i_redirect_pc[31:2], 2'b00}.
    - discard <= outstanding minus any response arriving this cycle (that response is dropped).
    - No issue this cycle.
    - Next state = DRAIN if the resulting discard > 0, else RUN.
  - DRAIN:
    - No requests.
    - Each rvalid decrements discard and is not enqueued.
    - When discard reaches 0, go to RUN.
  - DRAIN + i_redirect: the new target replaces pc. Discard counting continues unchanged; the redirect does not restart the drain.
- Downstream stall (i_ready = 0) holds o_valid, o_instr and o_pc stable. Issue stops once the credit limit is reached.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum {FETCH_RUN, FETCH_DRAIN};
  - the constant INSTR_BYTES = 4;
  - the fetch-entry struct {instr[31:0], pc[31:0]}.
  - The existing ENDIAN_SWP_32 macro is reused, not redefined.
- One sub-module, sync_fifo: parameterised width and depth, push/pop/flush inputs, full/empty/count outputs. It is used for both the instruction FIFO and the PC tag queue.

Test Plan:
- Reset with RESET_PC = 32'h100, gnt = 1, rvalid one cycle after each issue, rdata = big-endian 32'h13000000 (LE addi x0,x0,0 = 32'h00000013):
  - required: o_imem_addr sequence 0x100, 0x104, 0x108;
  - first o_valid two cycles after the first issue, with o_instr = 32'h00000013 and o_pc = 0x100.
- Backpressure: i_ready = 0 for 10 cycles with DEPTH = 2:
  - exactly 2 issues then o_imem_req = 0;
  - o_pc holds 0x100;
  - releasing i_ready yields pops in PC order 0x100, 0x104, 0x108 with no loss or duplication.
- Redirect with 2 requests outstanding, i_redirect_pc = 32'h203:
  - the next 2 rvalids are dropped;
  - the FSM is in DRAIN for those cycles;
  - the first post-redirect request has address 0x200 and the first delivered o_pc = 0x200.
- Redirect coincident with an rvalid and a pop (outstanding = 1):
  - that response is dropped, discard = 0, the FSM stays in RUN;
  - o_valid = 0 the next cycle and the next issue is at the target.
- Wrap: RESET_PC = 32'hFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Synchronous reset asserted mid-DRAIN:
  - the next cycle has o_valid = 0, o_imem_req = 0, pc = RESET_PC;
  - fetching resumes from RESET_PC one cycle after i_rst deasserts.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction-fetch stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef ENDIAN_SWP_32
`define ENDIAN_SWP_32(x) {x[7:0], x[15:8], x[23:16], x[31:24]}
`endif

package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with flush; registered storage, head read out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_data  = mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push needs, so push-on-full is legal then.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit : PC owner, credit-limited imem requester and decode-side FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned DEPTH          = 2,
  parameter bit          MEM_BIG_ENDIAN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] tag_count, fifo_count;
  logic [CW:0]   credit_used;
  logic [31:0]   tag_pc, rdata_le;
  logic          tag_full, tag_empty, fifo_full, fifo_empty;
  logic          issue, accept, flush, pop, resp_tracked;
  fetch_entry_t  push_entry, head_entry;

  generate
    if (MEM_BIG_ENDIAN) begin : g_swap
      assign rdata_le = `ENDIAN_SWP_32(i_imem_rdata);
    end else begin : g_noswap
      assign rdata_le = i_imem_rdata;
    end
  endgenerate

  // Tag queue occupancy doubles as the count of live outstanding requests.
  assign credit_used  = {1'b0, tag_count} + {1'b0, fifo_count};
  assign o_imem_req   = !i_rst && (state_q == FETCH_RUN) && !i_redirect &&
                        (credit_used < (CW+1)'(DEPTH));
  assign o_imem_addr  = pc_q;
  assign issue        = o_imem_req && i_imem_gnt;
  assign resp_tracked = i_imem_rvalid && !tag_empty;
  assign accept       = resp_tracked && (state_q == FETCH_RUN) && !i_redirect;
  assign flush        = i_redirect && (state_q == FETCH_RUN);
  assign pop          = o_valid && i_ready;
  assign push_entry   = '{instr: rdata_le, pc: tag_pc};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    case (state_q)
      FETCH_RUN: begin
        if (i_redirect) begin
          pc_d      = i_redirect_pc & 32'hFFFF_FFFC;
          discard_d = tag_count - {{(CW-1){1'b0}}, resp_tracked};
          if (discard_d != '0) begin
            state_d = FETCH_DRAIN;
          end
        end else if (issue) begin
          pc_d = pc_q + INSTR_BYTES;
        end
      end
      FETCH_DRAIN: begin
        if (i_redirect) begin
          pc_d = i_redirect_pc & 32'hFFFF_FFFC;
        end
        if (i_imem_rvalid) begin
          discard_d = discard_q - 1'b1;
          if (discard_d == '0) begin
            state_d = FETCH_RUN;
          end
        end
      end
      default: begin
        state_d = FETCH_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= FETCH_RUN;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (issue),
    .i_pop   (accept),
    .i_flush (flush),
    .i_data  (pc_q),
    .o_data  (tag_pc),
    .o_full  (tag_full),
    .o_empty (tag_empty),
    .o_count (tag_count)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_pop   (pop),
    .i_flush (flush),
    .i_data  (push_entry),
    .o_data  (head_entry),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_valid = !fifo_empty;
  assign o_instr = head_entry.instr;
  assign o_pc    = head_entry.pc;

`ifndef SYNTHESIS
  a_no_fifo_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(accept && fifo_full && !pop));
  a_no_tag_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(issue && tag_full && !accept));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit : directed + random stimulus against a program-order fetch model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, valid, ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_BIG_ENDIAN(1'b1)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} dent_t;

  mreq_t       mq[$];   // requests inside the memory, oldest first
  dent_t       eq[$];   // instructions waiting for decode, program order
  logic [31:0] pc_m;    // next address the model expects to be fetched
  int          stale, live, cyc, last_due, lat_min, lat_max;
  bit          nop_mode, after_rst;
  int          n_chk, n_pass;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return ((x & 32'h0000_00FF) << 24) | ((x & 32'h0000_FF00) << 8) |
           ((x >> 8) & 32'h0000_FF00) | (x >> 24);
  endfunction

  function automatic logic [31:0] prog(input logic [31:0] a);
    if (nop_mode) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit resp_now();
    return (mq.size() > 0) && (mq[0].due <= cyc);
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit r, input bit red, input logic [31:0] rpc,
                       input bit gnt, input bit rdy);
    bit    rv, exp_req;
    mreq_t m;
    dent_t d;
    int    due;
    @(negedge clk);
    rv          = !r && resp_now();
    rst         = r;
    redirect    = red;
    redirect_pc = rpc;
    imem_gnt    = gnt;
    ready       = rdy;
    imem_rvalid = rv;
    imem_rdata  = rv ? bswap(prog(mq[0].addr)) : $urandom;
    #1;
    exp_req = !r && (stale == 0) && !red && (live + eq.size() < DEPTH);
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, pc_m);
    check_eq("o_valid", valid, eq.size() != 0);
    if (eq.size() != 0) begin
      check_eq("o_pc", pc, eq[0].pc);
      check_eq("o_instr", instr, eq[0].instr);
    end else if (after_rst) begin
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_instr", instr, 32'h0);
    end
    if (r) begin
      pc_m = RESET_PC; mq.delete(); eq.delete();
      stale = 0; live = 0; last_due = 0; after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (red) begin
        stale = mq.size();
        live  = 0;
        eq.delete();
      end else if (eq.size() != 0 && rdy) begin
        void'(eq.pop_front());
      end
      if (rv) begin
        m = mq.pop_front();
        if (stale > 0) stale--;
        else begin
          live--;
          d.instr = prog(m.addr);
          d.pc    = m.addr;
          eq.push_back(d);
        end
      end
      if (exp_req && gnt) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        m.addr = pc_m;
        m.due  = due;
        mq.push_back(m);
        last_due = due;
        live++;
        pc_m = pc_m + 32'd4;
      end
      if (red) pc_m = rpc & 32'hFFFF_FFFC;
    end
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; last_due = 0;
    stale = 0; live = 0; pc_m = RESET_PC; after_rst = 1'b0;
    lat_min = 1; lat_max = 1; nop_mode = 1'b1;
    redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0; ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);

    // Straight-line fetch of big-endian NOPs
    cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1);

    // Backpressure from reset, then release
    nop_mode = 1'b0;
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1);

    // Redirect with two requests outstanding
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && !(live == 2 && !resp_now()); i++) cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 32'h0000_0203, 1, 1);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1);

    // Redirect coinciding with a response and a pop, one outstanding
    for (int i = 0; i < 40 && !(live == 1 && resp_now() && eq.size() != 0); i++)
      cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 32'h0000_0400, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);

    // Address wrap at the top of the address space
    cycle(0, 1, 32'hFFFF_FFF8, 1, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1);

    // Reset while draining stale responses
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 40 && !(live == 2 && !resp_now()); i++) cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 32'h0000_0300, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1);

    // Random traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      bit r, red;
      r   = ($urandom_range(999, 0) < 3);
      red = !r && ($urandom_range(99, 0) < 3);
      cycle(r, red, $urandom, $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
